fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width of one register.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter FWD_DEPTH, default 2, number of tracked producer slots beyond EX; slot 1 = youngest (MEM), slot FWD_DEPTH = oldest (WB); legal range 1..4.
REQ-004 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: advance  input  1  pipeline moves one stage this cycle.
REQ-007 SHALL have ports: flush  input  1  squash all tracked producers.
REQ-008 SHALL have ports: ex_valid, ex_we, ex_is_load  input  1 each  EX instruction valid, writes GPR, is a load.
REQ-009 SHALL have ports: ex_rd_addr, rs1_addr, rs2_addr  input  REG_ADDR_WIDTH each  EX destination and source addresses.
REQ-010 SHALL have ports: stage_data  input  FWD_DEPTH*REG_WIDTH  result of slot i on bits [i*REG_WIDTH-1 -: REG_WIDTH].
REQ-011 SHALL have ports: stage_rdy  input  FWD_DEPTH  bit i-1 = slot i data valid (0 while load data outstanding).
REQ-012 SHALL have ports: fwd1_en, fwd2_en  output  1 each  forward select for ALU operand 1/2.
REQ-013 SHALL have ports: fwd1_data, fwd2_data  output  REG_WIDTH each  forwarded operand values.
REQ-014 SHALL have ports: stall  output  1  load-use hazard; EX must hold.
REQ-015 SHALL have ports: stall_cnt  output  32  stall cycle counter (see Configuration).

Function
REQ-016 SHALL hold per slot a registered record {valid, we, is_load, rd_addr}.
REQ-017 SHALL, on a clock edge with advance=1, shift slot i into slot i+1, drop slot FWD_DEPTH, and load slot 1 with the EX record when stall=0, else with a bubble (valid=0).
REQ-018 SHALL hold all records unchanged when advance=0 and flush=0.
REQ-019 SHALL clear every valid bit on a clock edge with flush=1; flush wins over simultaneous advance.
REQ-020 SHALL treat a slot as matching operand k when valid=1, we=1, rd_addr==rsk_addr and rsk_addr!=0; x0 never matches.
REQ-021 SHALL select, per operand independently, the lowest-numbered (youngest) matching slot only.
REQ-022 SHALL, when the selected slot has stage_rdy=1, drive fwdk_en=1 and fwdk_data=that slot's stage_data in the same cycle (combinational, zero latency).
REQ-023 SHALL, when the selected slot has stage_rdy=0, drive fwdk_en=0, fwdk_data=0 and stall=1; an older ready match SHALL NOT be used instead.
REQ-024 SHALL drive fwdk_en=0 and fwdk_data=0 when no slot matches.
REQ-025 SHALL assert stall only when ex_valid=1.
REQ-026 SHALL handle rs1_addr==rs2_addr by forwarding identical data on both operands.

Reset
REQ-027 SHALL, on a clock edge with rst=1, clear all record valid bits and stall_cnt; rst overrides flush and advance.
REQ-028 SHALL drive fwd1_en=fwd2_en=0, fwd1_data=fwd2_data=0, stall=0 and stall_cnt=0 in the cycle after reset; a hazard in progress mid-reset is discarded.

Configuration
REQ-029 SHALL, with macro FWD_SCOREBOARD_STALL_CNT_EN defined, increment stall_cnt by 1 on each clock edge with stall=1 and rst=0, saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without FWD_SCOREBOARD_STALL_CNT_EN, tie stall_cnt to 0 and instantiate no counter register.

Verification
REQ-031 SHALL cover: ALU producer rd=5 in slot 1, stage_rdy=2'b01, stage_data slot1=0x0000_00AA, rs1=5 -> fwd1_en=1, fwd1_data=0xAA, stall=0.
REQ-032 SHALL cover: rd=7 in slot 1 (0x11) and slot 2 (0x22), both ready, rs2=7 -> fwd2_data=0x11 (youngest wins).
REQ-033 SHALL cover: load rd=3 in slot 1, stage_rdy=2'b00, EX rs1=3, advance=1 -> stall=1 one cycle, slot 1 becomes bubble; next cycle load in slot 2 with rdy=1, data 0x55 -> stall=0, fwd1_data=0x55; stall_cnt=1 when macro defined.
REQ-034 SHALL cover: producer rd=0 with we=1, rs1=0 -> fwd1_en=0, fwd1_data=0.
REQ-035 SHALL cover: flush=1 and advance=1 same edge with valid EX record -> all slots invalid next cycle, no forward.
REQ-036 SHALL cover: rst=1 during an active stall -> next cycle stall=0, stall_cnt=0, all fwd outputs 0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: pipeline-side bundle of the forwarding scoreboard (EX record, producer results, forward/stall outputs).
interface fwd_scoreboard_if #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_DEPTH      = 2
);
    logic                           advance;
    logic                           flush;
    logic                           ex_valid;
    logic                           ex_we;
    logic                           ex_is_load;
    logic [REG_ADDR_WIDTH-1:0]      ex_rd_addr;
    logic [REG_ADDR_WIDTH-1:0]      rs1_addr;
    logic [REG_ADDR_WIDTH-1:0]      rs2_addr;
    logic [FWD_DEPTH*REG_WIDTH-1:0] stage_data;
    logic [FWD_DEPTH-1:0]           stage_rdy;
    logic                           fwd1_en;
    logic                           fwd2_en;
    logic [REG_WIDTH-1:0]           fwd1_data;
    logic [REG_WIDTH-1:0]           fwd2_data;
    logic                           stall;
    logic [31:0]                    stall_cnt;

    modport master (
        output advance, flush, ex_valid, ex_we, ex_is_load, ex_rd_addr, rs1_addr, rs2_addr,
               stage_data, stage_rdy,
        input  fwd1_en, fwd2_en, fwd1_data, fwd2_data, stall, stall_cnt
    );

    modport slave (
        input  advance, flush, ex_valid, ex_we, ex_is_load, ex_rd_addr, rs1_addr, rs2_addr,
               stage_data, stage_rdy,
        output fwd1_en, fwd2_en, fwd1_data, fwd2_data, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight GPR producers, forwards youngest ready result, stalls on unready load-use.
// Optional stall cycle counter enabled by defining FWD_SCOREBOARD_STALL_CNT_EN.
module fwd_scoreboard #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_DEPTH      = 2
) (
    input logic             clk,
    input logic             rst,
    fwd_scoreboard_if.slave bus
);
    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic                      is_load;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
    } rec_t;

    rec_t                 slot [FWD_DEPTH];
    logic                 hit1, hit2, rdy1, rdy2, stall;
    logic [REG_WIDTH-1:0] d1, d2;

    // slot[0] is the youngest producer (MEM), slot[FWD_DEPTH-1] the oldest (WB)
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < FWD_DEPTH; i++) slot[i].valid <= 1'b0;
        end else if (bus.advance) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) slot[i] <= slot[i-1];
            slot[0] <= stall ? '0 : '{bus.ex_valid, bus.ex_we, bus.ex_is_load, bus.ex_rd_addr};
        end
    end

    // scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        d1   = '0;
        d2   = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (slot[i].valid && slot[i].we && slot[i].rd_addr == bus.rs1_addr && bus.rs1_addr != '0) begin
                hit1 = 1'b1;
                rdy1 = bus.stage_rdy[i];
                d1   = bus.stage_data[i*REG_WIDTH +: REG_WIDTH];
            end
            if (slot[i].valid && slot[i].we && slot[i].rd_addr == bus.rs2_addr && bus.rs2_addr != '0) begin
                hit2 = 1'b1;
                rdy2 = bus.stage_rdy[i];
                d2   = bus.stage_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign stall         = bus.ex_valid && ((hit1 && !rdy1) || (hit2 && !rdy2));
    assign bus.stall     = stall;
    assign bus.fwd1_en   = hit1 && rdy1;
    assign bus.fwd2_en   = hit2 && rdy2;
    assign bus.fwd1_data = (hit1 && rdy1) ? d1 : '0;
    assign bus.fwd2_data = (hit2 && rdy2) ? d2 : '0;

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (stall && !(&cnt)) cnt <= cnt + 32'd1;
    end
    assign bus.stall_cnt = cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus random traffic checked against a queue-based producer model.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5), .FWD_DEPTH(2)) bus ();
    fwd_scoreboard #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5), .FWD_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit       v;
        bit       we;
        bit       ld;
        bit [4:0] rd;
    } rec_t;

    rec_t        q[$];
    bit   [31:0] m_cnt;
    bit          exp_stall;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void resolve(input bit [4:0] rs, output bit en, output bit [31:0] d, output bit pend);
        en = 0;
        d = 0;
        pend = 0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].v && q[i].we && q[i].rd == rs && rs != 0) begin
                if (bus.stage_rdy[i]) begin
                    en = 1;
                    d = bus.stage_data[i*32 +: 32];
                end else pend = 1;
                return;
            end
    endfunction

    task automatic drive(input bit adv, input bit fl, input bit v, input bit we, input bit ld,
                         input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2,
                         input bit [1:0] rdy, input bit [63:0] data);
        bus.advance = adv;
        bus.flush = fl;
        bus.ex_valid = v;
        bus.ex_we = we;
        bus.ex_is_load = ld;
        bus.ex_rd_addr = rd;
        bus.rs1_addr = r1;
        bus.rs2_addr = r2;
        bus.stage_rdy = rdy;
        bus.stage_data = data;
    endtask

    task automatic settle();
        bit e1, e2, p1, p2;
        bit [31:0] d1, d2;
        #4;
        resolve(bus.rs1_addr, e1, d1, p1);
        resolve(bus.rs2_addr, e2, d2, p2);
        exp_stall = bus.ex_valid && (p1 || p2);
        chk("fwd1_en", {31'd0, bus.fwd1_en}, {31'd0, e1});
        chk("fwd2_en", {31'd0, bus.fwd2_en}, {31'd0, e2});
        chk("fwd1_data", bus.fwd1_data, d1);
        chk("fwd2_data", bus.fwd2_data, d2);
        chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
        chk("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    task automatic tick();
        rec_t r;
        @(posedge clk);
        if (rst) begin
            foreach (q[i]) q[i].v = 0;
            m_cnt = 0;
        end else begin
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
            if (bus.flush) foreach (q[i]) q[i].v = 0;
            else if (bus.advance) begin
                r = '{bus.ex_valid && !exp_stall, bus.ex_we, bus.ex_is_load, bus.ex_rd_addr};
                void'(q.pop_back());
                q.push_front(r);
            end
        end
        #1;
    endtask

    initial begin
        q = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        m_cnt = 0;
        exp_stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 0;
        // ALU producer forwarded from MEM
        drive(1, 0, 1, 1, 0, 5, 0, 0, 2'b00, 0); settle(); tick();
        drive(0, 0, 1, 0, 0, 0, 5, 0, 2'b01, {32'h0, 32'hAA}); settle();
        chk("d031_en", {31'd0, bus.fwd1_en}, 1);
        chk("d031_data", bus.fwd1_data, 32'hAA);
        chk("d031_stall", {31'd0, bus.stall}, 0);
        tick();
        // same rd in both slots: youngest wins, identical on both operands
        drive(1, 0, 1, 1, 0, 7, 0, 0, 2'b00, 0); settle(); tick(); settle(); tick();
        drive(0, 0, 1, 0, 0, 0, 7, 7, 2'b11, {32'h22, 32'h11}); settle();
        chk("d032_fwd2", bus.fwd2_data, 32'h11);
        chk("d032_fwd1", bus.fwd1_data, 32'h11);
        tick();
        // load-use stall then forward from WB
        drive(1, 0, 1, 1, 1, 3, 0, 0, 2'b11, 0); settle(); tick();
        drive(1, 0, 1, 1, 0, 9, 3, 0, 2'b00, 0); settle();
        chk("d033_stall", {31'd0, bus.stall}, 1);
        tick();
        drive(1, 0, 1, 1, 0, 9, 3, 0, 2'b10, {32'h55, 32'h0}); settle();
        chk("d033_unstall", {31'd0, bus.stall}, 0);
        chk("d033_data", bus.fwd1_data, 32'h55);
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        chk("d033_cnt", bus.stall_cnt, 1);
`else
        chk("d033_cnt", bus.stall_cnt, 0);
`endif
        tick();
        // x0 never forwards
        drive(1, 0, 1, 1, 0, 0, 0, 0, 2'b11, 0); settle(); tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 2'b11, {32'h77, 32'h77}); settle();
        chk("d034_en", {31'd0, bus.fwd1_en}, 0);
        chk("d034_data", bus.fwd1_data, 0);
        tick();
        // flush beats advance
        drive(1, 0, 1, 1, 0, 4, 0, 0, 2'b11, 0); settle(); tick();
        drive(1, 1, 1, 1, 0, 4, 0, 0, 2'b11, 0); settle(); tick();
        drive(0, 0, 1, 0, 0, 0, 4, 4, 2'b11, {64{1'b1}}); settle();
        chk("d035_en1", {31'd0, bus.fwd1_en}, 0);
        chk("d035_en2", {31'd0, bus.fwd2_en}, 0);
        tick();
        // reset in the middle of a stall
        drive(1, 0, 1, 1, 1, 6, 0, 0, 2'b11, 0); settle(); tick();
        drive(1, 0, 1, 1, 0, 9, 6, 0, 2'b00, 0); settle();
        chk("d036_pre", {31'd0, bus.stall}, 1);
        tick();
        settle();
        rst = 1;
        tick();
        rst = 0;
        drive(0, 0, 1, 0, 0, 0, 6, 6, 2'b11, {64{1'b1}}); settle();
        chk("d036_stall", {31'd0, bus.stall}, 0);
        chk("d036_cnt", bus.stall_cnt, 0);
        chk("d036_en", {31'd0, bus.fwd1_en | bus.fwd2_en}, 0);
        chk("d036_data", bus.fwd1_data | bus.fwd2_data, 0);
        tick();
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
                  {32'($urandom), 32'($urandom)});
            rst = $urandom_range(0, 60) == 0;
            settle();
            tick();
            rst = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
